// File: rtl/mouse_axis_emu.sv
// PS/2 mouse to analog-stick emulation: saturating signed X/Y positions, mouse buttons into the joystick word.
// Latency: a packet update is visible on ax/ay one clk_sys cycle after the strobe toggle is seen.
// Backpressure: none. Every packet is accepted unless a release condition discards it in the same cycle.
module mouse_axis_emu #(
  parameter int AXIS_W       = 8,
  parameter int SHIFT        = 1,
  parameter int STEP_MAX     = 10,
  parameter int BTN_POS      = 5,
  parameter int RECENTER_DIV = 0,
  parameter int IDLE_CYC     = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [24:0]           ps2_mouse,
  input  logic [2*AXIS_W-1:0]   joya,
  input  logic [7:0]            joy_dig,
  input  logic                  halt,
  input  logic                  recenter_en,
  output logic [AXIS_W-1:0]     ax,
  output logic [AXIS_W-1:0]     ay,
  output logic [7:0]            j_out,
  output logic                  emu_active
);

  // Delta arithmetic runs wide enough for the 9-bit raw delta and for pos + delta without overflow.
  localparam int CW = (AXIS_W + 2 > 12) ? AXIS_W + 2 : 12;
  localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int RW = (RECENTER_DIV > 1) ? $clog2(RECENTER_DIV) : 1;

  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
  localparam logic [RW-1:0] DIV_LAST  = RW'((RECENTER_DIV > 0) ? RECENTER_DIV - 1 : 0);

  localparam logic signed [CW-1:0] STEP_HI = CW'(STEP_MAX);
  localparam logic signed [CW-1:0] STEP_LO = -STEP_HI;
  localparam logic signed [CW-1:0] POS_HI  = CW'((1 << (AXIS_W - 1)) - 1);
  localparam logic signed [CW-1:0] POS_LO  = ~POS_HI;

  logic                     old_stb;
  logic                     pkt;
  logic                     rel;
  logic                     idle_exp;
  logic                     div_run;
  logic                     tick;
  logic signed [AXIS_W-1:0] pos_x;
  logic signed [AXIS_W-1:0] pos_y;
  logic [IW-1:0]            idle_cnt;
  logic [RW-1:0]            div_cnt;

  // Shift, clamp and add one raw mouse delta to a position, saturating instead of wrapping.
  function automatic logic signed [AXIS_W-1:0] apply_delta(
    input logic signed [AXIS_W-1:0] pos,
    input logic                     sgn,
    input logic [7:0]               mag
  );
    logic signed [CW-1:0] ds;
    logic signed [CW-1:0] dc;
    logic signed [CW-1:0] sum;
    ds = {{(CW-8){sgn}}, mag};
    ds = ds >>> SHIFT;
    if (ds > STEP_HI)      dc = STEP_HI;
    else if (ds < STEP_LO) dc = STEP_LO;
    else                   dc = ds;
    sum = {{(CW-AXIS_W){pos[AXIS_W-1]}}, pos} + dc;
    if (sum > POS_HI)      sum = POS_HI;
    else if (sum < POS_LO) sum = POS_LO;
    return sum[AXIS_W-1:0];
  endfunction

  // One LSB toward zero; zero stays zero.
  function automatic logic signed [AXIS_W-1:0] toward_zero(input logic signed [AXIS_W-1:0] pos);
    if (pos == '0)            return pos;
    else if (pos[AXIS_W-1])   return pos + AXIS_W'(1);
    else                      return pos - AXIS_W'(1);
  endfunction

  assign pkt      = ps2_mouse[24] ^ old_stb;
  assign idle_exp = (IDLE_CYC > 0) && (idle_cnt == IDLE_LAST);
  assign rel      = (joya != '0) | halt | idle_exp;
  assign div_run  = (RECENTER_DIV > 0) && recenter_en && emu_active;
  assign tick     = div_run && (div_cnt == DIV_LAST);

  // Position, ownership, idle and recentre state; release beats packet, packet beats recentre tick.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      old_stb    <= ps2_mouse[24];
      pos_x      <= '0;
      pos_y      <= '0;
      emu_active <= 1'b0;
      idle_cnt   <= '0;
      div_cnt    <= '0;
    end else begin
      old_stb <= ps2_mouse[24];
      div_cnt <= (div_run && !tick) ? div_cnt + 1'b1 : '0;
      if (rel) begin
        emu_active <= 1'b0;
        pos_x      <= '0;
        pos_y      <= '0;
        idle_cnt   <= '0;
      end else if (pkt) begin
        emu_active <= 1'b1;
        pos_x      <= apply_delta(pos_x, ps2_mouse[4], ps2_mouse[15:8]);
        pos_y      <= apply_delta(pos_y, ps2_mouse[5], ps2_mouse[23:16]);
        idle_cnt   <= '0;
      end else begin
        if (tick) begin
          pos_x <= toward_zero(pos_x);
          pos_y <= toward_zero(pos_y);
        end
        if ((IDLE_CYC > 0) && emu_active && !idle_exp)
          idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // Hand the axes and button bits to the mouse while it owns them, otherwise pass the real stick through.
  always_comb begin
    ax    = emu_active ? pos_x : joya[AXIS_W-1:0];
    ay    = emu_active ? pos_y : joya[2*AXIS_W-1:AXIS_W];
    j_out = joy_dig;
    if (emu_active) begin
      j_out[BTN_POS]   = ps2_mouse[0];
      j_out[BTN_POS+1] = ps2_mouse[1];
    end
  end

endmodule

// File: tb/tb_mouse_axis_emu.sv
// Bench for mouse_axis_emu: directed scenarios plus randomized traffic against a behavioural model.
// The model tracks positions as plain integers and is compared on every clock.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mouse_axis_emu;

  localparam int AW   = 8;
  localparam int SH   = 1;
  localparam int SMAX = 10;
  localparam int BP   = 5;
  localparam int RDIV = 4;
  localparam int IDLE = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] ps2_mouse = '0;
  logic [15:0] joya = '0;
  logic [7:0]  joy_dig = '0;
  logic        halt = 1'b0;
  logic        recenter_en = 1'b0;
  logic [7:0]  ax;
  logic [7:0]  ay;
  logic [7:0]  j_out;
  logic        emu_active;

  int checks = 0;
  int errors = 0;

  int m_px = 0;
  int m_py = 0;
  int m_idle = 0;
  int m_div = 0;
  bit m_act = 1'b0;
  bit m_old = 1'b0;

  mouse_axis_emu #(
    .AXIS_W(AW), .SHIFT(SH), .STEP_MAX(SMAX), .BTN_POS(BP),
    .RECENTER_DIV(RDIV), .IDLE_CYC(IDLE)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .joya(joya),
    .joy_dig(joy_dig), .halt(halt), .recenter_en(recenter_en),
    .ax(ax), .ay(ay), .j_out(j_out), .emu_active(emu_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int axis_delta(input bit sgn, input logic [7:0] mag);
    int d;
    d = sgn ? int'(mag) - 256 : int'(mag);
    d = d >>> SH;
    if (d > SMAX)  d = SMAX;
    if (d < -SMAX) d = -SMAX;
    return d;
  endfunction

  function automatic int sat(input int v);
    int hi;
    hi = (1 << (AW - 1)) - 1;
    if (v > hi)      return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic int toward0(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  function automatic logic [7:0] exp_j();
    logic [7:0] j;
    j = joy_dig;
    if (m_act) begin
      j[BP]   = ps2_mouse[0];
      j[BP+1] = ps2_mouse[1];
    end
    return j;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit pkt;
    bit rel;
    bit tck;
    if (!reset_n) begin
      m_px = 0; m_py = 0; m_act = 1'b0; m_idle = 0; m_div = 0;
      m_old = ps2_mouse[24];
    end else begin
      pkt = (ps2_mouse[24] != m_old);
      m_old = ps2_mouse[24];
      rel = (joya != 0) || halt || (m_idle == IDLE - 1);
      tck = recenter_en && m_act && (m_div == RDIV - 1);
      m_div = (recenter_en && m_act) ? (m_div + 1) % RDIV : 0;
      if (rel) begin
        m_act = 1'b0; m_px = 0; m_py = 0; m_idle = 0;
      end else if (pkt) begin
        m_px = sat(m_px + axis_delta(ps2_mouse[4], ps2_mouse[15:8]));
        m_py = sat(m_py + axis_delta(ps2_mouse[5], ps2_mouse[23:16]));
        m_act = 1'b1;
        m_idle = 0;
      end else begin
        if (tck) begin
          m_px = toward0(m_px);
          m_py = toward0(m_py);
        end
        if (m_act && m_idle < IDLE - 1) m_idle++;
      end
    end
  endtask

  task automatic step();
    logic [7:0] ex;
    logic [7:0] ey;
    @(posedge clk_sys);
    model_update();
    #1;
    ex = m_act ? 8'(m_px) : joya[7:0];
    ey = m_act ? 8'(m_py) : joya[15:8];
    check("ax", ax, ex);
    check("ay", ay, ey);
    check("j_out", j_out, exp_j());
    check("emu_active", emu_active, m_act);
  endtask

  task automatic send(input bit sx, input logic [7:0] bx, input bit sy, input logic [7:0] by,
                      input logic [1:0] btn);
    ps2_mouse = {~ps2_mouse[24], by, bx, 2'b00, sy, sx, 2'b00, btn};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int rate;

    // 1: single packet, +40 shifted to 20 and clamped to 10
    do_reset();
    check("rst_ax", ax, 8'h00);
    check("rst_act", emu_active, 1'b0);
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    check("t1_ax", ax, 8'h0A);
    check("t1_ay", ay, 8'h00);
    check("t1_act", emu_active, 1'b1);

    // 2: saturation at +127, then a -16 delta
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
      step();
      check("t2_sat", ax, (10 * k > 127) ? 127 : 10 * k);
    end
    send(1'b1, 8'hF0, 1'b0, 8'h00, 2'b00);
    step();
    check("t2_neg", ax, 8'h77);

    // 3: real stick movement releases and discards the coincident packet; halt blocks packets
    do_reset();
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    joya = 16'h0005;
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    check("t3_rel_act", emu_active, 1'b0);
    check("t3_rel_ax", ax, 8'h05);
    check("t3_rel_ay", ay, 8'h00);
    joya = 16'h0000;
    halt = 1'b1;
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    check("t3_halt_act", emu_active, 1'b0);
    step();
    halt = 1'b0;
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    check("t3_restart_ax", ax, 8'h0A);
    check("t3_restart_act", emu_active, 1'b1);

    // 4: recentre every 4 cycles; a packet on a tick cycle wins
    do_reset();
    recenter_en = 1'b1;
    send(1'b0, 8'h06, 1'b1, 8'hFC, 2'b00);
    step();
    check("t4_x0", ax, 8'h03);
    check("t4_y0", ay, 8'hFE);
    for (int c = 1; c <= 15; c++) begin
      if (c == 10) send(1'b0, 8'h00, 1'b0, 8'h00, 2'b00);
      step();
      if (c == 4)  begin check("t4_x4", ax, 8'h02);  check("t4_y4", ay, 8'hFF); end
      if (c == 8)  begin check("t4_x8", ax, 8'h01);  check("t4_y8", ay, 8'h00); end
      if (c == 12) begin check("t4_x12", ax, 8'h00); check("t4_y12", ay, 8'h00); end
    end
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    check("t4_pkt_wins", ax, 8'h0A);
    repeat (4) step();
    check("t4_tick_after", ax, 8'h09);
    recenter_en = 1'b0;

    // 5: idle timeout, and a packet mid-count restarting it
    do_reset();
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    repeat (15) step();
    check("t5_alive15", emu_active, 1'b1);
    step();
    check("t5_drop16", emu_active, 1'b0);
    check("t5_ax_pass", ax, 8'h00);
    send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
    step();
    repeat (9) step();
    send(1'b0, 8'h00, 1'b0, 8'h00, 2'b00);
    step();
    repeat (15) step();
    check("t5_alive25", emu_active, 1'b1);
    step();
    check("t5_drop26", emu_active, 1'b0);

    // 6: mouse buttons override the selected joystick bits only while active
    do_reset();
    joy_dig = 8'h80;
    step();
    check("t6_pass", j_out, 8'h80);
    send(1'b0, 8'h00, 1'b0, 8'h00, 2'b01);
    step();
    check("t6_btn", j_out, 8'hA0);
    halt = 1'b1;
    step();
    check("t6_release", j_out, 8'h80);
    halt = 1'b0;

    // Randomized traffic with varying packet rate, occasional stick motion, halt and recentre toggles
    do_reset();
    rate = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(1, 40);
      joya = ($urandom_range(0, 23) == 0) ? 16'($urandom) : 16'h0000;
      halt = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 63) == 0) recenter_en = ~recenter_en;
      joy_dig = 8'($urandom);
      if ($urandom_range(0, rate - 1) == 0)
        send(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
             2'($urandom_range(0, 3)));
      else if ($urandom_range(0, 7) == 0)
        ps2_mouse[1:0] = 2'($urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
Parametrised successor to the top-level PS/2-mouse-to-analog-stick emulation. It converts HPS PS/2 mouse packets into saturating signed paddle/analog X/Y positions and maps mouse buttons into the digital joystick word. It adds configurable width, sensitivity, per-packet clamp, button position, an auto-recentre mode and an idle hand-back timeout. It sits between hps_io and the core's JOY1X/JOY1Y/JOY1 inputs and passes the real analog stick through whenever emulation is inactive.

Parameters:
AXIS_W, 8, output axis width (signed two's complement), 4..12
SHIFT, 1, arithmetic right shift applied to each raw 9-bit mouse delta
STEP_MAX, 10, per-packet delta clamp magnitude, must be < 2^(AXIS_W-1)
BTN_POS, 5, joystick bit receiving mouse left button; right button goes to BTN_POS+1 (BTN_POS <= 6)
RECENTER_DIV, 0, cycles per recentre step; 0 disables recentre hardware
IDLE_CYC, 0, cycles without a packet before emulation releases; 0 disables

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
ps2_mouse  in  25  [24] toggle strobe, [23:16] Y delta, [15:8] X delta, [5] Y sign, [4] X sign, [1:0] buttons R,L
joya  in  2*AXIS_W  real analog stick, [AXIS_W-1:0] X, [2*AXIS_W-1:AXIS_W] Y
joy_dig  in  8  real digital joystick
halt  in  1  CPU halt / OSD active; forces release
recenter_en  in  1  enable auto-recentre (ignored when RECENTER_DIV=0)
ax  out  AXIS_W  X position to core
ay  out  AXIS_W  Y position to core
j_out  out  8  digital joystick to core
emu_active  out  1  mouse emulation owns the axes

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): pos_x=pos_y=0, emu_active=0, idle and recentre counters=0, old_stb<=ps2_mouse[24] (no spurious packet after reset). Outputs then equal the pass-through values.
- Packet detect: pkt = (ps2_mouse[24] != old_stb). old_stb is registered every cycle.
- Delta path per axis:
  - d9 = {sign, byte} as a signed 9-bit value.
  - ds = d9 >>> SHIFT.
  - dc = clamp(ds, -STEP_MAX, +STEP_MAX).
  - nxt = pos + dc, computed at AXIS_W+2 bits.
  - Saturate nxt to [-2^(AXIS_W-1), 2^(AXIS_W-1)-1]. There is no wrap-around.
- On pkt: pos_x/pos_y <= saturated nxt, emu_active <= 1, idle counter <= 0. Latency: the new value is visible on ax/ay one cycle after the cycle where pkt=1.
- Release condition: rel = (joya != 0) | halt | idle_expired.
  - On rel: emu_active <= 0, pos_x <= 0, pos_y <= 0, idle counter <= 0.
  - rel has priority over a simultaneous pkt; the packet is discarded.
- Idle timeout (IDLE_CYC>0): counter increments while emu_active=1 and pkt=0. idle_expired = (counter == IDLE_CYC-1). The counter stops at that value and clears on pkt or release.
- Recentre (RECENTER_DIV>0 and recenter_en=1 and emu_active=1):
  - Divider counts 0..RECENTER_DIV-1, then emits a tick and wraps.
  - On a tick each nonzero axis steps 1 LSB toward 0; an axis already at 0 stays 0.
  - pkt in the same cycle as a tick: the packet update wins and the tick is dropped. The divider still wraps.
  - recenter_en=0 or emu_active=0 holds the divider at 0.
- Outputs (combinational from registers/inputs):
  - ax = emu_active ? pos_x : joya X
  - ay = emu_active ? pos_y : joya Y
  - j_out = joy_dig, except when emu_active: j_out[BTN_POS] = ps2_mouse[0], j_out[BTN_POS+1] = ps2_mouse[1].
- halt held high keeps emu_active=0; packets arriving during halt are ignored. The first packet after halt falls restarts emulation from 0.

Test Plan:
1. Defaults; reset; toggle strobe with X sign=0, byte=0x28 (+40) -> ds=20 clamped to 10; ax=0x0A one cycle later; emu_active=1; ay=0.
2. Defaults; 14 packets of X=+40 -> ax rises by 10 per packet and saturates at 0x7F, never wraps. Then X sign=1, byte=0xF0 (-16) -> ax=0x77 (127-8).
3. Emulation active, pos_x=0x0A; same cycle set joya=0x0005 with a pkt -> emu_active=0 next cycle, pos cleared, ax=0x05, ay=0x00. With joya=0 and halt=1 -> no reactivation on a packet.
4. RECENTER_DIV=4, recenter_en=1, pos_x=3, pos_y=-2 -> after 4, 8 and 12 cycles (x,y) = (2,-1), (1,0), (0,0). A pkt coinciding with a tick applies only the packet delta.
5. IDLE_CYC=16; one packet, then silence -> emu_active drops 16 cycles after the packet and ax returns to joya X. A packet at cycle 10 restarts the count.
6. BTN_POS=5; emulation active, ps2_mouse[1:0]=2'b01, joy_dig=0x80 -> j_out=0xA0. After release -> j_out=0x80.
